// File: rtl/usart_rx_ctrl_pkg.sv
// usart_rx_ctrl_pkg
// Shared definitions for the USART receiver control front-end:
//   - config word field positions (same layout for write data and readback)
//   - read-response word field positions
//   - read arbiter FSM state encoding
// Optional build macro used by the design: USART_RX_RR_EN (see usart_rx_arb).
package usart_rx_ctrl_pkg;

  // Config word layout
  localparam int CFG_W        = 11;
  localparam int CFG_UCSZ_LSB = 0;
  localparam int CFG_UCSZ_W   = 3;
  localparam int CFG_UPM_LSB  = 3;
  localparam int CFG_UPM_W    = 2;
  localparam int CFG_UMSEL    = 5;
  localparam int CFG_U2X      = 6;
  localparam int CFG_MPCM     = 7;
  localparam int CFG_RXEN     = 8;
  localparam int CFG_RXCIE    = 9;
  localparam int CFG_DMAEN    = 10;

  // Format fields (ucsz, upm, umsel, u2x) occupy the contiguous low bits,
  // which lets the pending buffer hold them as one slice.
  localparam int CFG_FMT_W    = 7;

  // Read-response word layout
  localparam int RD_W         = 13;
  localparam int RD_UDR_LSB   = 0;
  localparam int RD_RX8       = 8;
  localparam int RD_FE        = 9;
  localparam int RD_PE        = 10;
  localparam int RD_DOR       = 11;
  localparam int RD_VALID     = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } arb_state_e;

  // Extract the format slice from a config word.
  function automatic logic [CFG_FMT_W-1:0] cfg_fmt(input logic [CFG_W-1:0] cfg);
    return cfg[CFG_FMT_W-1:0];
  endfunction

endpackage

// File: rtl/usart_rx_arb.sv
// usart_rx_arb
// Read arbiter between the CPU and the DMA channel for the receive buffer.
// One read takes four cycles: IDLE -> GRANT -> CAPTURE -> ACK -> IDLE.
// The winner is chosen and registered on leaving IDLE.
//
// Build macro USART_RX_RR_EN:
//   defined   - round-robin on a tie, the previous winner loses.
//   undefined - DMA has priority, but after STARVE_MAX consecutive DMA grants
//               made while the CPU was waiting, the CPU takes the next tie.
//               STARVE_MAX = 0 disables that limit.
//
// Ports:
//   i_fosk, i_rst_n        clock, asynchronous active-low reset
//   i_cpu_req, i_dma_req   level requests, held until acked
//   o_busy                 FSM is not IDLE
//   o_sample               FSM is in GRANT: the top samples the buffer now
//   o_cpu_ack, o_dma_ack   one-cycle registered acks, asserted in ACK
module usart_rx_arb
  import usart_rx_ctrl_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic i_fosk,
  input  logic i_rst_n,
  input  logic i_cpu_req,
  input  logic i_dma_req,
  output logic o_busy,
  output logic o_sample,
  output logic o_cpu_ack,
  output logic o_dma_ack
);

  arb_state_e state_reg;
  logic       win_dma_reg;
  logic       pick_dma;

`ifdef USART_RX_RR_EN
  logic last_dma_reg;

  always_comb begin
    pick_dma = i_dma_req & (~i_cpu_req | ~last_dma_reg);
  end
`else
  localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt_reg;
  logic             cpu_starved;

  always_comb begin
    cpu_starved = (STARVE_MAX != 0) && (32'(starve_cnt_reg) >= STARVE_MAX);
    pick_dma    = i_dma_req & (~i_cpu_req | ~cpu_starved);
  end
`endif

  always_ff @(posedge i_fosk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg      <= IDLE;
      win_dma_reg    <= 1'b0;
      o_cpu_ack      <= 1'b0;
      o_dma_ack      <= 1'b0;
`ifdef USART_RX_RR_EN
      last_dma_reg   <= 1'b0;
`else
      starve_cnt_reg <= '0;
`endif
    end else begin
      o_cpu_ack <= 1'b0;
      o_dma_ack <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (i_cpu_req || i_dma_req) begin
            state_reg   <= GRANT;
            win_dma_reg <= pick_dma;
`ifdef USART_RX_RR_EN
            last_dma_reg <= pick_dma;
`else
            // Only DMA wins taken over a waiting CPU count as starvation.
            if (!pick_dma || !i_cpu_req) begin
              starve_cnt_reg <= '0;
            end else if (starve_cnt_reg != {CNT_W{1'b1}}) begin
              starve_cnt_reg <= starve_cnt_reg + 1'b1;
            end
`endif
          end
        end
        GRANT:   state_reg <= CAPTURE;
        CAPTURE: begin
          state_reg <= ACK;
          o_cpu_ack <= ~win_dma_reg;
          o_dma_ack <= win_dma_reg;
        end
        ACK:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_busy   = (state_reg != IDLE);
  assign o_sample = (state_reg == GRANT);

endmodule

// File: rtl/usart_rx_ctrl.sv
// usart_rx_ctrl
// Control and access front-end of the USART receiver.
//   - Holds the applied receiver configuration. A format change (ucsz, upm,
//     umsel, u2x) written while the receiver is enabled is parked in a pending
//     buffer and only reaches the receiver when rxen is written 0.
//   - Arbitrates receive-buffer reads between CPU and DMA (usart_rx_arb),
//     captures the buffer into o_rd_data and pops the receive FIFO.
//   - Registers the RX-complete interrupt and the DMA request.
// Build macro: USART_RX_RR_EN selects round-robin arbitration (see usart_rx_arb).
//
// Ports:
//   i_fosk, i_rst_n               clock, asynchronous active-low reset
//   i_cfg_we, i_cfg_wdata         config write strobe and word
//   o_cfg_rdata, o_cfg_pending    applied config, format change held
//   i_cpu_rd_req / o_cpu_rd_ack   CPU read handshake
//   i_dma_rd_req / o_dma_rd_ack   DMA read handshake
//   o_rd_data                     {valid, dor, pe, fe, rx8, udr}
//   i_udr, i_rx8, i_fe, i_pe, i_dor, i_rxc   receiver buffer and flags
//   o_w_addr                      one-cycle FIFO pop strobe
//   o_RXEN, o_mpcm, o_umsel, o_u2x, o_ucsz, o_upm   applied config to receiver
//   o_rxc_irq, o_dma_req          registered interrupt and DMA request
module usart_rx_ctrl
  import usart_rx_ctrl_pkg::*;
#(
  parameter logic [2:0] UCSZ_RST   = 3'b011,
  parameter int         STARVE_MAX = 4
) (
  input  logic              i_fosk,
  input  logic              i_rst_n,
  input  logic              i_cfg_we,
  input  logic [CFG_W-1:0]  i_cfg_wdata,
  output logic [CFG_W-1:0]  o_cfg_rdata,
  output logic              o_cfg_pending,
  input  logic              i_cpu_rd_req,
  output logic              o_cpu_rd_ack,
  input  logic              i_dma_rd_req,
  output logic              o_dma_rd_ack,
  output logic [RD_W-1:0]   o_rd_data,
  input  logic [7:0]        i_udr,
  input  logic              i_rx8,
  input  logic              i_fe,
  input  logic              i_pe,
  input  logic              i_dor,
  input  logic              i_rxc,
  output logic              o_w_addr,
  output logic              o_RXEN,
  output logic              o_mpcm,
  output logic              o_umsel,
  output logic              o_u2x,
  output logic [2:0]        o_ucsz,
  output logic [1:0]        o_upm,
  output logic              o_rxc_irq,
  output logic              o_dma_req
);

  logic [CFG_W-1:0]     cfg_reg;
  logic [CFG_FMT_W-1:0] pend_fmt_reg;
  logic                 pend_valid_reg;
  logic [CFG_FMT_W-1:0] wr_fmt;

  logic [RD_W-1:0]      rd_data_reg;
  logic                 w_addr_reg;
  logic                 rxc_irq_reg;
  logic                 dma_req_reg;

  logic                 arb_busy;
  logic                 arb_sample;

  assign wr_fmt = cfg_fmt(i_cfg_wdata);

  // Config shadow and pending format buffer
  always_ff @(posedge i_fosk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cfg_reg        <= {{(CFG_W-CFG_UCSZ_W){1'b0}}, UCSZ_RST};
      pend_fmt_reg   <= '0;
      pend_valid_reg <= 1'b0;
    end else if (i_cfg_we) begin
      if (!i_cfg_wdata[CFG_RXEN]) begin
        // Disabling: a held format change is released in this same edge.
        cfg_reg <= i_cfg_wdata;
        if (pend_valid_reg) begin
          cfg_reg[CFG_FMT_W-1:0] <= pend_fmt_reg;
        end
        pend_valid_reg <= 1'b0;
      end else if (!cfg_reg[CFG_RXEN] || (wr_fmt == cfg_fmt(cfg_reg))) begin
        // Enable-with-format, or no format change at all.
        cfg_reg        <= i_cfg_wdata;
        pend_valid_reg <= 1'b0;
      end else begin
        // Receiver running: hold the format, apply the non-format bits now.
        cfg_reg[CFG_DMAEN:CFG_MPCM] <= i_cfg_wdata[CFG_DMAEN:CFG_MPCM];
        pend_fmt_reg                <= wr_fmt;
        pend_valid_reg              <= 1'b1;
      end
    end
  end

  usart_rx_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .i_fosk    (i_fosk),
    .i_rst_n   (i_rst_n),
    .i_cpu_req (i_cpu_rd_req),
    .i_dma_req (i_dma_rd_req),
    .o_busy    (arb_busy),
    .o_sample  (arb_sample),
    .o_cpu_ack (o_cpu_rd_ack),
    .o_dma_ack (o_dma_rd_ack)
  );

  // Buffer capture, FIFO pop and registered status outputs
  always_ff @(posedge i_fosk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_data_reg <= '0;
      w_addr_reg  <= 1'b0;
      rxc_irq_reg <= 1'b0;
      dma_req_reg <= 1'b0;
    end else begin
      w_addr_reg <= 1'b0;
      if (arb_sample) begin
        rd_data_reg[RD_UDR_LSB +: 8] <= i_udr;
        rd_data_reg[RD_RX8]          <= i_rx8;
        rd_data_reg[RD_FE]           <= i_fe;
        rd_data_reg[RD_PE]           <= i_pe;
        rd_data_reg[RD_DOR]          <= i_dor;
        rd_data_reg[RD_VALID]        <= i_rxc;
        // Pop only when there was a character to take.
        w_addr_reg                   <= i_rxc;
      end
      rxc_irq_reg <= i_rxc & cfg_reg[CFG_RXCIE];
      // Masked while a read is in flight so the DMA is not asked twice
      // for the character it is already fetching.
      dma_req_reg <= i_rxc & cfg_reg[CFG_DMAEN] & ~arb_busy;
    end
  end

  assign o_cfg_rdata   = cfg_reg;
  assign o_cfg_pending = pend_valid_reg;
  assign o_rd_data     = rd_data_reg;
  assign o_w_addr      = w_addr_reg;
  assign o_rxc_irq     = rxc_irq_reg;
  assign o_dma_req     = dma_req_reg;
  assign o_ucsz        = cfg_reg[CFG_UCSZ_LSB +: CFG_UCSZ_W];
  assign o_upm         = cfg_reg[CFG_UPM_LSB +: CFG_UPM_W];
  assign o_umsel       = cfg_reg[CFG_UMSEL];
  assign o_u2x         = cfg_reg[CFG_U2X];
  assign o_mpcm        = cfg_reg[CFG_MPCM];
  assign o_RXEN        = cfg_reg[CFG_RXEN];

endmodule

// File: tb/tb_usart_rx_ctrl.sv
// tb_usart_rx_ctrl
// Directed bench for usart_rx_ctrl. Read responses go through a scoreboard:
// stimulus pushes the expected {requester, rd_data}, a monitor pops on each ack.
// Config and timing checks are made inline. Honours USART_RX_RR_EN.
module tb_usart_rx_ctrl;

  logic        i_fosk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_cfg_we = 1'b0;
  logic [10:0] i_cfg_wdata = '0;
  logic [10:0] o_cfg_rdata;
  logic        o_cfg_pending;
  logic        i_cpu_rd_req = 1'b0;
  logic        o_cpu_rd_ack;
  logic        i_dma_rd_req = 1'b0;
  logic        o_dma_rd_ack;
  logic [12:0] o_rd_data;
  logic [7:0]  i_udr = '0;
  logic        i_rx8 = 1'b0, i_fe = 1'b0, i_pe = 1'b0, i_dor = 1'b0, i_rxc = 1'b0;
  logic        o_w_addr, o_RXEN, o_mpcm, o_umsel, o_u2x;
  logic [2:0]  o_ucsz;
  logic [1:0]  o_upm;
  logic        o_rxc_irq, o_dma_req;

  always #5 i_fosk = ~i_fosk;

  usart_rx_ctrl #(
    .UCSZ_RST   (3'b011),
    .STARVE_MAX (4)
  ) dut (
    .i_fosk        (i_fosk),
    .i_rst_n       (i_rst_n),
    .i_cfg_we      (i_cfg_we),
    .i_cfg_wdata   (i_cfg_wdata),
    .o_cfg_rdata   (o_cfg_rdata),
    .o_cfg_pending (o_cfg_pending),
    .i_cpu_rd_req  (i_cpu_rd_req),
    .o_cpu_rd_ack  (o_cpu_rd_ack),
    .i_dma_rd_req  (i_dma_rd_req),
    .o_dma_rd_ack  (o_dma_rd_ack),
    .o_rd_data     (o_rd_data),
    .i_udr         (i_udr),
    .i_rx8         (i_rx8),
    .i_fe          (i_fe),
    .i_pe          (i_pe),
    .i_dor         (i_dor),
    .i_rxc         (i_rxc),
    .o_w_addr      (o_w_addr),
    .o_RXEN        (o_RXEN),
    .o_mpcm        (o_mpcm),
    .o_umsel       (o_umsel),
    .o_u2x         (o_u2x),
    .o_ucsz        (o_ucsz),
    .o_upm         (o_upm),
    .o_rxc_irq     (o_rxc_irq),
    .o_dma_req     (o_dma_req)
  );

  typedef struct packed {
    logic        is_dma;
    logic [12:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  // Scoreboard monitor
  always @(negedge i_fosk) begin
    if (o_cpu_rd_ack || o_dma_rd_ack) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_ack_unexpected: got cpu=%0b dma=%0b data=0x%h, required no ack",
                 o_cpu_rd_ack, o_dma_rd_ack, o_rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        if ((o_cpu_rd_ack && o_dma_rd_ack) || (o_dma_rd_ack != mon_e.is_dma) ||
            (o_rd_data !== mon_e.data)) begin
          n_err++;
          $display("FAIL rd_ack: got cpu=%0b dma=%0b data=0x%h, required %s data=0x%h",
                   o_cpu_rd_ack, o_dma_rd_ack, o_rd_data,
                   mon_e.is_dma ? "dma" : "cpu", mon_e.data);
        end else begin
          $display("ok   rd_ack %s data=0x%h", mon_e.is_dma ? "dma" : "cpu", o_rd_data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic cfg_write(input logic [10:0] v);
    @(posedge i_fosk); #1;
    i_cfg_we = 1'b1;
    i_cfg_wdata = v;
    @(posedge i_fosk); #1;
    i_cfg_we = 1'b0;
  endtask

  task automatic expect_rd(input logic is_dma, input logic [12:0] data);
    exp_t e;
    e.is_dma = is_dma;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Requests are assumed already raised; drops both after n acks, then
  // watches a few more cycles for stray acks or pops.
  task automatic run_reads(input int n, output int got, output int wa);
    got = 0;
    wa = 0;
    for (int k = 0; k < n * 4 + 8 && got < n; k++) begin
      @(negedge i_fosk);
      if (o_cpu_rd_ack || o_dma_rd_ack) got++;
      if (o_w_addr) wa++;
    end
    i_cpu_rd_req = 1'b0;
    i_dma_rd_req = 1'b0;
    repeat (4) begin
      @(negedge i_fosk);
      if (o_cpu_rd_ack || o_dma_rd_ack) got++;
      if (o_w_addr) wa++;
    end
  endtask

  function automatic logic [11:0] status_bits();
    return {o_RXEN, o_mpcm, o_umsel, o_u2x, o_upm, o_cfg_pending, o_w_addr,
            o_cpu_rd_ack, o_dma_rd_ack, o_rxc_irq, o_dma_req};
  endfunction

  logic [4:0] wa_seq, ack_seq;
  logic [5:0] order;
  int         got, wa;

  initial begin
`ifdef USART_RX_RR_EN
    order = 6'b010101;   // D C D C D C (bit i = DMA wins read i)
`else
    order = 6'b101111;   // D D D D C D
`endif
    // Reset state
    repeat (3) @(posedge i_fosk);
    #1;
    check("reset_status", 32'(status_bits()), 32'h0);
    check("reset_ucsz", 32'(o_ucsz), 32'h3);
    check("reset_rd_data", 32'(o_rd_data), 32'h0);
    @(negedge i_fosk);
    i_rst_n = 1'b1;

    // Enable with 8-bit format
    cfg_write(11'h103);
    check("en_rxen_ucsz_pend", 32'({o_RXEN, o_ucsz, o_cfg_pending}), 32'({1'b1, 3'b011, 1'b0}));
    check("en_rdata", 32'(o_cfg_rdata), 32'h103);

    // Format change while enabled is held; mpcm applies at once
    cfg_write(11'h187);
    check("hold_ucsz", 32'(o_ucsz), 32'h3);
    check("hold_pending", 32'(o_cfg_pending), 32'h1);
    check("hold_rdata", 32'(o_cfg_rdata), 32'h183);
    check("hold_mpcm", 32'(o_mpcm), 32'h1);

    // Disable releases the held format
    cfg_write(11'h007);
    check("release_ucsz", 32'(o_ucsz), 32'h7);
    check("release_pend_rxen", 32'({o_cfg_pending, o_RXEN}), 32'h0);
    check("release_rdata", 32'(o_cfg_rdata), 32'h007);

    // A: CPU read of a valid character with a framing error
    i_udr = 8'hA5; i_fe = 1'b1; i_rxc = 1'b1;
    @(posedge i_fosk); #1;
    i_cpu_rd_req = 1'b1;
    expect_rd(1'b0, 13'h12A5);
    for (int k = 0; k < 5; k++) begin
      @(negedge i_fosk);
      wa_seq[k] = o_w_addr;
      ack_seq[k] = o_cpu_rd_ack;
      if (k == 3) i_cpu_rd_req = 1'b0;
    end
    check("A_waddr_timing", 32'(wa_seq), 32'b00100);
    check("A_ack_timing", 32'(ack_seq), 32'b01000);
    check("A_rd_data_held", 32'(o_rd_data), 32'h12A5);

    // B: simultaneous requests, no character available
    i_udr = 8'h3C; i_fe = 1'b0; i_rx8 = 1'b1; i_rxc = 1'b0;
    @(posedge i_fosk); #1;
    i_cpu_rd_req = 1'b1;
    i_dma_rd_req = 1'b1;
    expect_rd(1'b1, 13'h013C);
    run_reads(1, got, wa);
    check("B_ack_count", 32'(got), 32'd1);
    check("B_waddr_count", 32'(wa), 32'd0);

    // CPU-only read so the contention run starts from a known arbiter history
    @(posedge i_fosk); #1;
    i_cpu_rd_req = 1'b1;
    expect_rd(1'b0, 13'h013C);
    run_reads(1, got, wa);
    check("C_pre_ack_count", 32'(got), 32'd1);

    // C: back-to-back contention, grant order checked by the scoreboard
    @(posedge i_fosk); #1;
    i_cpu_rd_req = 1'b1;
    i_dma_rd_req = 1'b1;
    for (int i = 0; i < 6; i++) expect_rd(order[i], 13'h013C);
    run_reads(6, got, wa);
    check("C_ack_count", 32'(got), 32'd6);

    // D: interrupt and DMA request, DMA request masked while busy
    cfg_write(11'h703);
    check("D_cfg", 32'(o_cfg_rdata), 32'h703);
    i_udr = 8'h5A; i_rx8 = 1'b0; i_pe = 1'b1;
    @(posedge i_fosk); #1;
    i_rxc = 1'b1;
    @(negedge i_fosk);
    check("D_irq_before_edge", 32'({o_rxc_irq, o_dma_req}), 32'b00);
    @(negedge i_fosk);
    check("D_irq_dmareq_rise", 32'({o_rxc_irq, o_dma_req}), 32'b11);
    i_dma_rd_req = 1'b1;
    expect_rd(1'b1, 13'h145A);
    @(negedge i_fosk);
    check("D_dmareq_grant_edge", 32'(o_dma_req), 32'h1);
    @(negedge i_fosk);
    check("D_dmareq_busy1", 32'({o_rxc_irq, o_dma_req}), 32'b10);
    @(negedge i_fosk);
    check("D_dmareq_busy2", 32'({o_dma_rd_ack, o_dma_req}), 32'b10);
    i_dma_rd_req = 1'b0;
    @(negedge i_fosk);
    @(negedge i_fosk);
    check("D_dmareq_idle_again", 32'(o_dma_req), 32'h1);

    // E: reset asserted during CAPTURE
    @(posedge i_fosk); #1;
    i_cpu_rd_req = 1'b1;
    repeat (3) @(negedge i_fosk);
    i_rst_n = 1'b0;
    #1;
    check("E_reset_status", 32'(status_bits()), 32'h0);
    check("E_reset_ucsz_rd", 32'({o_ucsz, o_rd_data}), 32'({3'b011, 13'h0}));
    i_cpu_rd_req = 1'b0;
    repeat (2) @(negedge i_fosk);
    i_rst_n = 1'b1;
    repeat (6) @(negedge i_fosk);
    check("end_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
